alu_result_checker: RTL and testbench

- Synthesizable response-side checker that sits on the `alu` output bus and is driven by the same vector source that drives `alu`.
- Samples each applied vector (a, b, control) together with the ALU's result and four flags, and recomputes the expected result with an internal golden model.
- Compares result and flags, keeps pass/fail counts, and captures the first failing vector for readout.
- Replaces manual waveform/`$monitor` inspection in lab ALU regression runs.

---
 rtl/alu_result_checker.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_alu_result_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// ---------------------------------------------------------------------------
// alu_result_checker
//
// Response-side checker for the lab ALU. It watches the same vector stream
// that drives the ALU, recomputes the expected result and flags with a golden
// model, and reports a per-vector verdict. It also keeps pass/fail counters
// and captures the first failing vector of each run.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, vec_total      begin a run of vec_total vectors (sampled on start)
//   in_valid, a, b,       one applied vector plus the ALU response to it
//   control, out, flags
//   busy, done            run in progress / run complete (level)
//   result_valid,         one-cycle verdict pulse per checked vector;
//   mismatch              mismatch qualifies result_valid
//   pass_count,           saturating per-run counters
//   fail_count
//   first_fail_*          snapshot of the first failing vector of the run
//
// Timing: a vector accepted in cycle T is registered at the end of T, checked
// during T+1, and its verdict and counter updates are visible in T+2.
// ---------------------------------------------------------------------------
module alu_result_checker #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] vec_total,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       control,
   input  logic [WIDTH-1:0] out,
   input  logic             zeroFlag,
   input  logic             overflowFlag,
   input  logic             carryoutFlag,
   input  logic             negativeFlag,
   output logic             busy,
   output logic             done,
   output logic             result_valid,
   output logic             mismatch,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             first_fail_valid,
   output logic [WIDTH-1:0] first_fail_a,
   output logic [WIDTH-1:0] first_fail_b,
   output logic [2:0]       first_fail_ctrl,
   output logic [WIDTH-1:0] first_fail_out,
   output logic [WIDTH-1:0] first_fail_exp
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // ---------------- control state ----------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] accept_left_q, accept_left_d;   // vectors still to accept
   logic [CNT_W-1:0] checked_left_q, checked_left_d; // verdicts still to produce
   logic             run_start;
   logic             accept;

   // ---------------- stage 1: captured vector ----------------
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]       s1_ctrl_q, s1_ctrl_d;
   logic [WIDTH-1:0] s1_out_q, s1_out_d;
   logic             s1_zero_q, s1_zero_d;
   logic             s1_ovf_q, s1_ovf_d;
   logic             s1_cout_q, s1_cout_d;
   logic             s1_neg_q, s1_neg_d;

   // ---------------- golden model ----------------
   logic [WIDTH:0]   sum_ext;
   logic [WIDTH-1:0] exp_result;
   logic             exp_carry;
   logic             exp_ovf;
   logic             arith_op;
   logic             vec_fail;

   // ---------------- stage 2: verdict and run statistics ----------------
   logic             result_valid_q, result_valid_d;
   logic             mismatch_q, mismatch_d;
   logic [CNT_W-1:0] pass_count_q, pass_count_d;
   logic [CNT_W-1:0] fail_count_q, fail_count_d;
   logic             ff_valid_q, ff_valid_d;
   logic [WIDTH-1:0] ff_a_q, ff_a_d;
   logic [WIDTH-1:0] ff_b_q, ff_b_d;
   logic [2:0]       ff_ctrl_q, ff_ctrl_d;
   logic [WIDTH-1:0] ff_out_q, ff_out_d;
   logic [WIDTH-1:0] ff_exp_q, ff_exp_d;

   // ------------------------------------------------------------------
   // Run FSM. A start always passes through RUN, even for vec_total == 0;
   // with nothing to check the RUN state exits on the next cycle, so done
   // appears two cycles after start.
   // ------------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      accept_left_d  = accept_left_q;
      checked_left_d = checked_left_q;
      run_start      = 1'b0;
      accept         = (state_q == ST_RUN) && in_valid && (accept_left_q != '0);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d        = ST_RUN;
               accept_left_d  = vec_total;
               checked_left_d = vec_total;
               run_start      = 1'b1;
            end
         end
         ST_RUN: begin
            if (accept) begin
               accept_left_d = accept_left_q - 1'b1;
            end
            if (s1_valid_q) begin
               checked_left_d = checked_left_q - 1'b1;
            end
            // Leave on the cycle after the last verdict became visible.
            if (checked_left_q == '0) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage 1 capture; data registers hold when nothing is accepted.
   always_comb begin
      s1_valid_d = accept;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_ctrl_d  = s1_ctrl_q;
      s1_out_d   = s1_out_q;
      s1_zero_d  = s1_zero_q;
      s1_ovf_d   = s1_ovf_q;
      s1_cout_d  = s1_cout_q;
      s1_neg_d   = s1_neg_q;
      if (accept) begin
         s1_a_d    = a;
         s1_b_d    = b;
         s1_ctrl_d = control;
         s1_out_d  = out;
         s1_zero_d = zeroFlag;
         s1_ovf_d  = overflowFlag;
         s1_cout_d = carryoutFlag;
         s1_neg_d  = negativeFlag;
      end
   end

   // Golden model on the stage 1 vector.
   always_comb begin
      sum_ext    = '0;
      exp_result = '0;
      exp_carry  = 1'b0;
      exp_ovf    = 1'b0;
      arith_op   = (s1_ctrl_q == 3'b001) || (s1_ctrl_q == 3'b010);
      case (s1_ctrl_q)
         3'b001: begin
            sum_ext    = {1'b0, s1_a_q} + {1'b0, s1_b_q};
            exp_result = sum_ext[WIDTH-1:0];
            exp_carry  = sum_ext[WIDTH];
            exp_ovf    = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                         (exp_result[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         3'b010: begin
            // a + ~b + 1 so carry-out reads as "no borrow" (a >= b unsigned).
            sum_ext    = {1'b0, s1_a_q} + {1'b0, ~s1_b_q} + (WIDTH+1)'(1);
            exp_result = sum_ext[WIDTH-1:0];
            exp_carry  = sum_ext[WIDTH];
            exp_ovf    = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                         (exp_result[WIDTH-1] != s1_a_q[WIDTH-1]);
         end
         3'b011: exp_result = s1_a_q & s1_b_q;
         3'b100: exp_result = s1_a_q | s1_b_q;
         3'b101: exp_result = s1_a_q ^ s1_b_q;
         3'b110: exp_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
         3'b111: exp_result = s1_a_q << s1_b_q[4:0];
         default: exp_result = '0;
      endcase

      // Carry and overflow are only meaningful for ADD/SUB.
      vec_fail = (s1_out_q != exp_result) ||
                 (s1_zero_q != (exp_result == '0)) ||
                 (s1_neg_q != exp_result[WIDTH-1]) ||
                 (arith_op && ((s1_cout_q != exp_carry) || (s1_ovf_q != exp_ovf)));
   end

   // Stage 2: verdict, saturating counters and first-failure snapshot.
   always_comb begin
      result_valid_d = s1_valid_q;
      mismatch_d     = s1_valid_q && vec_fail;
      pass_count_d   = pass_count_q;
      fail_count_d   = fail_count_q;
      ff_valid_d     = ff_valid_q;
      ff_a_d         = ff_a_q;
      ff_b_d         = ff_b_q;
      ff_ctrl_d      = ff_ctrl_q;
      ff_out_d       = ff_out_q;
      ff_exp_d       = ff_exp_q;

      if (run_start) begin
         pass_count_d = '0;
         fail_count_d = '0;
         ff_valid_d   = 1'b0;
         ff_a_d       = '0;
         ff_b_d       = '0;
         ff_ctrl_d    = '0;
         ff_out_d     = '0;
         ff_exp_d     = '0;
      end else if (s1_valid_q) begin
         if (vec_fail) begin
            if (fail_count_q != CNT_MAX) begin
               fail_count_d = fail_count_q + 1'b1;
            end
            if (!ff_valid_q) begin
               ff_valid_d = 1'b1;
               ff_a_d     = s1_a_q;
               ff_b_d     = s1_b_q;
               ff_ctrl_d  = s1_ctrl_q;
               ff_out_d   = s1_out_q;
               ff_exp_d   = exp_result;
            end
         end else if (pass_count_q != CNT_MAX) begin
            pass_count_d = pass_count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         accept_left_q  <= '0;
         checked_left_q <= '0;
         s1_valid_q     <= 1'b0;
         s1_a_q         <= '0;
         s1_b_q         <= '0;
         s1_ctrl_q      <= '0;
         s1_out_q       <= '0;
         s1_zero_q      <= 1'b0;
         s1_ovf_q       <= 1'b0;
         s1_cout_q      <= 1'b0;
         s1_neg_q       <= 1'b0;
         result_valid_q <= 1'b0;
         mismatch_q     <= 1'b0;
         pass_count_q   <= '0;
         fail_count_q   <= '0;
         ff_valid_q     <= 1'b0;
         ff_a_q         <= '0;
         ff_b_q         <= '0;
         ff_ctrl_q      <= '0;
         ff_out_q       <= '0;
         ff_exp_q       <= '0;
      end else begin
         state_q        <= state_d;
         accept_left_q  <= accept_left_d;
         checked_left_q <= checked_left_d;
         s1_valid_q     <= s1_valid_d;
         s1_a_q         <= s1_a_d;
         s1_b_q         <= s1_b_d;
         s1_ctrl_q      <= s1_ctrl_d;
         s1_out_q       <= s1_out_d;
         s1_zero_q      <= s1_zero_d;
         s1_ovf_q       <= s1_ovf_d;
         s1_cout_q      <= s1_cout_d;
         s1_neg_q       <= s1_neg_d;
         result_valid_q <= result_valid_d;
         mismatch_q     <= mismatch_d;
         pass_count_q   <= pass_count_d;
         fail_count_q   <= fail_count_d;
         ff_valid_q     <= ff_valid_d;
         ff_a_q         <= ff_a_d;
         ff_b_q         <= ff_b_d;
         ff_ctrl_q      <= ff_ctrl_d;
         ff_out_q       <= ff_out_d;
         ff_exp_q       <= ff_exp_d;
      end
   end

   assign busy             = (state_q == ST_RUN);
   assign done             = (state_q == ST_DONE);
   assign result_valid     = result_valid_q;
   assign mismatch         = mismatch_q;
   assign pass_count       = pass_count_q;
   assign fail_count       = fail_count_q;
   assign first_fail_valid = ff_valid_q;
   assign first_fail_a     = ff_a_q;
   assign first_fail_b     = ff_b_q;
   assign first_fail_ctrl  = ff_ctrl_q;
   assign first_fail_out   = ff_out_q;
   assign first_fail_exp   = ff_exp_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// ---------------------------------------------------------------------------
// tb_alu_result_checker
//
// Directed bench for alu_result_checker. Inputs are driven and outputs are
// sampled on the falling edge; a vector driven at falling edge N has its
// verdict visible at falling edge N+2.
// ---------------------------------------------------------------------------
module tb_alu_result_checker;

   localparam int WIDTH = 32;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] vec_total;
   logic             in_valid;
   logic [WIDTH-1:0] a, b, out;
   logic [2:0]       control;
   logic             zeroFlag, overflowFlag, carryoutFlag, negativeFlag;
   logic             busy, done, result_valid, mismatch, first_fail_valid;
   logic [CNT_W-1:0] pass_count, fail_count;
   logic [WIDTH-1:0] first_fail_a, first_fail_b, first_fail_out, first_fail_exp;
   logic [2:0]       first_fail_ctrl;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .vec_total(vec_total),
      .in_valid(in_valid), .a(a), .b(b), .control(control), .out(out),
      .zeroFlag(zeroFlag), .overflowFlag(overflowFlag),
      .carryoutFlag(carryoutFlag), .negativeFlag(negativeFlag),
      .busy(busy), .done(done), .result_valid(result_valid), .mismatch(mismatch),
      .pass_count(pass_count), .fail_count(fail_count),
      .first_fail_valid(first_fail_valid), .first_fail_a(first_fail_a),
      .first_fail_b(first_fail_b), .first_fail_ctrl(first_fail_ctrl),
      .first_fail_out(first_fail_out), .first_fail_exp(first_fail_exp)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
      $display("check %-24s observed %0h expected %0h", tag, obs, expv);
   endtask

   // Drive one vector: ctrl, a, b, out, {zero, overflow, carry, negative}.
   task automatic vec(input logic [2:0] c, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] vo, input logic [3:0] fl);
      in_valid     = 1'b1;
      control      = c;
      a            = va;
      b            = vb;
      out          = vo;
      zeroFlag     = fl[3];
      overflowFlag = fl[2];
      carryoutFlag = fl[1];
      negativeFlag = fl[0];
   endtask

   task automatic idle_vec();
      in_valid = 1'b0;
      control  = '0;
      a = '0; b = '0; out = '0;
      zeroFlag = 1'b0; overflowFlag = 1'b0; carryoutFlag = 1'b0; negativeFlag = 1'b0;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] n);
      start     = 1'b1;
      vec_total = n;
      tick();
      start     = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      vec_total = '0;
      idle_vec();
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;

      // ---- reset state ----
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_pass", 32'(pass_count), 32'd0);
      chk("rst_ffv", 32'(first_fail_valid), 32'd0);

      // ---- reset mid-run with vectors in flight ----
      do_start(16'd5);
      vec(3'b001, 32'd1, 32'd2, 32'd3, 4'b0000);
      tick();
      vec(3'b001, 32'd2, 32'd2, 32'd4, 4'b0000);
      tick();
      vec(3'b001, 32'd3, 32'd2, 32'd5, 4'b0000);
      chk("mid_rv_before_rst", 32'(result_valid), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_vec();
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_pass", 32'(pass_count), 32'd0);
      chk("mid_fail", 32'(fail_count), 32'd0);
      chk("mid_rv0", 32'(result_valid), 32'd0);
      tick();
      chk("mid_rv1", 32'(result_valid), 32'd0);
      tick();
      chk("mid_rv2", 32'(result_valid), 32'd0);
      chk("mid_pass2", 32'(pass_count), 32'd0);

      // ---- three passing vectors, back to back ----
      do_start(16'd3);
      chk("run_busy", 32'(busy), 32'd1);
      vec(3'b001, 32'd5, 32'h16, 32'h1B, 4'b0000);
      tick();
      vec(3'b011, 32'd0, 32'h16, 32'h0, 4'b1000);
      chk("pass_rv_t1", 32'(result_valid), 32'd0);
      tick();
      vec(3'b010, 32'd0, 32'd1, 32'hFFFF_FFFF, 4'b0001);
      chk("pass_rv_add", 32'(result_valid), 32'd1);
      chk("pass_mm_add", 32'(mismatch), 32'd0);
      chk("pass_cnt1", 32'(pass_count), 32'd1);
      tick();
      idle_vec();
      chk("pass_rv_and", 32'(result_valid), 32'd1);
      chk("pass_cnt2", 32'(pass_count), 32'd2);
      tick();
      chk("pass_rv_sub", 32'(result_valid), 32'd1);
      chk("pass_mm_sub", 32'(mismatch), 32'd0);
      chk("pass_cnt3", 32'(pass_count), 32'd3);
      chk("pass_fail0", 32'(fail_count), 32'd0);
      chk("pass_done_early", 32'(done), 32'd0);
      tick();
      chk("pass_done", 32'(done), 32'd1);
      chk("pass_busy", 32'(busy), 32'd0);
      chk("pass_rv_end", 32'(result_valid), 32'd0);

      // ---- ADD overflow reported wrong ----
      do_start(16'd1);
      chk("ovf_cnt_clr", 32'(pass_count), 32'd0);
      vec(3'b001, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b0001);
      tick();
      idle_vec();
      tick();
      chk("ovf_rv", 32'(result_valid), 32'd1);
      chk("ovf_mm", 32'(mismatch), 32'd1);
      chk("ovf_fail", 32'(fail_count), 32'd1);
      chk("ovf_pass", 32'(pass_count), 32'd0);
      chk("ovf_ffv", 32'(first_fail_valid), 32'd1);
      chk("ovf_ff_ctrl", 32'(first_fail_ctrl), 32'd1);
      chk("ovf_ff_exp", first_fail_exp, 32'h8000_0000);
      chk("ovf_ff_a", first_fail_a, 32'h7FFF_FFFF);
      tick();
      chk("ovf_done", 32'(done), 32'd1);

      // ---- two failures, then an extra vector beyond vec_total ----
      do_start(16'd2);
      chk("two_ffv_clr", 32'(first_fail_valid), 32'd0);
      vec(3'b101, 32'hF0, 32'h0F, 32'hFE, 4'b0000);
      tick();
      vec(3'b111, 32'd1, 32'd4, 32'h8, 4'b0000);
      tick();
      vec(3'b000, 32'd0, 32'd0, 32'd1, 4'b0000);
      chk("two_mm1", 32'(mismatch), 32'd1);
      chk("two_fail1", 32'(fail_count), 32'd1);
      tick();
      idle_vec();
      chk("two_mm2", 32'(mismatch), 32'd1);
      chk("two_fail2", 32'(fail_count), 32'd2);
      chk("two_ff_ctrl", 32'(first_fail_ctrl), 32'd5);
      chk("two_ff_out", first_fail_out, 32'hFE);
      chk("two_ff_exp", first_fail_exp, 32'hFF);
      chk("two_ff_b", first_fail_b, 32'h0F);
      tick();
      chk("extra_rv", 32'(result_valid), 32'd0);
      chk("extra_fail", 32'(fail_count), 32'd2);
      chk("extra_done", 32'(done), 32'd1);

      // ---- empty run ----
      do_start(16'd0);
      chk("zero_done_t1", 32'(done), 32'd0);
      tick();
      chk("zero_done_t2", 32'(done), 32'd1);
      chk("zero_pass", 32'(pass_count), 32'd0);
      chk("zero_fail", 32'(fail_count), 32'd0);

      // ---- fail counter saturation ----
      do_start(16'd3);
      force dut.fail_count_q = 16'hFFFE;
      tick();
      release dut.fail_count_q;
      chk("sat_preload", 32'(fail_count), 32'hFFFE);
      vec(3'b000, 32'd0, 32'd0, 32'd1, 4'b0000);
      tick();
      vec(3'b100, 32'd1, 32'd2, 32'd0, 4'b0000);
      tick();
      vec(3'b110, 32'd1, 32'd2, 32'd0, 4'b0000);
      chk("sat_fail1", 32'(fail_count), 32'hFFFF);
      tick();
      idle_vec();
      chk("sat_fail2", 32'(fail_count), 32'hFFFF);
      tick();
      chk("sat_mm3", 32'(mismatch), 32'd1);
      chk("sat_fail3", 32'(fail_count), 32'hFFFF);
      tick();
      chk("sat_done", 32'(done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
